// File: rtl/i2c_check_pkg.sv
// ============================================================================
// i2c_check_pkg : edge-type encodings and defaults shared by the timing checkers
// Rev 1.0
// ============================================================================
`default_nettype none

package i2c_check_pkg;

  localparam logic [1:0] EDGE_RISE = 2'd0;
  localparam logic [1:0] EDGE_FALL = 2'd1;
  localparam logic [1:0] EDGE_ANY  = 2'd2;

  localparam int CW_DEFAULT = 16;

endpackage

`default_nettype wire

// File: rtl/i2c_edge_sel.sv
// ============================================================================
// i2c_edge_sel : one-cycle event strobe on the selected edge of a sync signal
// Rev 1.0
// ============================================================================
`default_nettype none

module i2c_edge_sel
  import i2c_check_pkg::*;
#(
  parameter logic [1:0] EDGE = EDGE_RISE
) (
  input  logic clk,
  input  logic s,
  output logic ev
);

  // Sampled every cycle, reset included, so the first post-reset cycle sees no edge.
  logic s_q;

  always_ff @(posedge clk) begin
    s_q <= s;
  end

  if (EDGE == EDGE_RISE) begin : g_rise
    assign ev = s & ~s_q;
  end else if (EDGE == EDGE_FALL) begin : g_fall
    assign ev = ~s & s_q;
  end else begin : g_any
    assign ev = s ^ s_q;
  end

endmodule

`default_nettype wire

// File: rtl/i2c_timing_check.sv
// ============================================================================
// i2c_timing_check : flags s1-event to s2-event distances shorter than lim
// Rev 1.0
// ============================================================================
`default_nettype none

module i2c_timing_check
  import i2c_check_pkg::*;
#(
  parameter logic [1:0] E1_EDGE = EDGE_RISE,
  parameter logic [1:0] E2_EDGE = EDGE_RISE,
  parameter int         CW      = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s1,
  input  logic          s2,
  input  logic [CW-1:0] lim,
  output logic          vio,
  output logic [CW-1:0] vio_dist,
  output logic [15:0]   vio_cnt
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic          ev1;
  logic          ev2;
  logic          hit;
  logic [CW-1:0] cnt;

  i2c_edge_sel #(.EDGE(E1_EDGE)) u_ev1 (
    .clk (clk),
    .s   (s1),
    .ev  (ev1)
  );

  i2c_edge_sel #(.EDGE(E2_EDGE)) u_ev2 (
    .clk (clk),
    .s   (s2),
    .ev  (ev2)
  );

  // Uses the pre-update count, so a coincident s1 event measures the older one.
  assign hit = ev2 && (cnt < lim);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= CNT_MAX;
      vio      <= 1'b0;
      vio_dist <= '0;
      vio_cnt  <= '0;
    end else begin
      if (ev1) begin
        cnt <= CW'(1);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end

      vio <= hit;
      if (hit) begin
        vio_dist <= cnt;
        if (vio_cnt != 16'hFFFF) begin
          vio_cnt <= vio_cnt + 16'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_timing_check.sv
// ============================================================================
// tb_i2c_timing_check : EE/EL/LE/CW=4 checkers against a timestamp-based model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_i2c_timing_check;
  import i2c_check_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s1  = 1'b0;
  logic        s2  = 1'b0;
  logic [15:0] lim_ee = 16'd10, lim_el = 16'd4, lim_le = 16'd8;
  logic [3:0]  lim_c4 = 4'd15;

  logic        vio_ee, vio_el, vio_le, vio_c4;
  logic [15:0] dist_ee, dist_el, dist_le;
  logic [3:0]  dist_c4;
  logic [15:0] cnt_ee, cnt_el, cnt_le, cnt_c4;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  i2c_timing_check #(.E1_EDGE(EDGE_RISE), .E2_EDGE(EDGE_RISE), .CW(16)) u_ee (
    .clk(clk), .rst(rst), .s1(s1), .s2(s2), .lim(lim_ee),
    .vio(vio_ee), .vio_dist(dist_ee), .vio_cnt(cnt_ee));
  i2c_timing_check #(.E1_EDGE(EDGE_RISE), .E2_EDGE(EDGE_ANY), .CW(16)) u_el (
    .clk(clk), .rst(rst), .s1(s1), .s2(s2), .lim(lim_el),
    .vio(vio_el), .vio_dist(dist_el), .vio_cnt(cnt_el));
  i2c_timing_check #(.E1_EDGE(EDGE_ANY), .E2_EDGE(EDGE_RISE), .CW(16)) u_le (
    .clk(clk), .rst(rst), .s1(s1), .s2(s2), .lim(lim_le),
    .vio(vio_le), .vio_dist(dist_le), .vio_cnt(cnt_le));
  i2c_timing_check #(.E1_EDGE(EDGE_RISE), .E2_EDGE(EDGE_RISE), .CW(4)) u_c4 (
    .clk(clk), .rst(rst), .s1(s1), .s2(s2), .lim(lim_c4),
    .vio(vio_c4), .vio_dist(dist_c4), .vio_cnt(cnt_c4));

  // Model: remember the cycle number of the last s1 event, distance is elapsed cycles.
  int     e1k [4] = '{0, 0, 2, 0};
  int     e2k [4] = '{0, 2, 0, 0};
  longint maxd[4] = '{65535, 65535, 65535, 15};
  bit     p1[4], p2[4], seen[4], mv[4];
  longint last_t[4], md[4], mc[4];
  longint cyc = 0;
  bit     model_on = 0;

  function automatic bit edge_of(int kind, bit cur, bit prev);
    if (kind == 0) return cur & ~prev;
    if (kind == 1) return ~cur & prev;
    return cur ^ prev;
  endfunction

  always @(posedge clk) begin
    longint lims[4];
    lims = '{longint'(lim_ee), longint'(lim_el), longint'(lim_le), longint'(lim_c4)};
    cyc++;
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        seen[k] = 0; mv[k] = 0; md[k] = 0; mc[k] = 0;
      end else begin
        longint d;
        bit a1, a2;
        a1 = edge_of(e1k[k], s1, p1[k]);
        a2 = edge_of(e2k[k], s2, p2[k]);
        d  = seen[k] ? cyc - last_t[k] : maxd[k];
        if (d > maxd[k]) d = maxd[k];
        mv[k] = 0;
        if (a2 && d < lims[k]) begin
          mv[k] = 1;
          md[k] = d;
          if (mc[k] < 65535) mc[k]++;
        end
        if (a1) begin
          seen[k] = 1;
          last_t[k] = cyc;
        end
      end
      p1[k] = s1;
      p2[k] = s2;
    end
    if (rst) model_on = 1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      chk("ee_cycle", {vio_ee, dist_ee, cnt_ee}, {mv[0], 16'(md[0]), 16'(mc[0])});
      chk("el_cycle", {vio_el, dist_el, cnt_el}, {mv[1], 16'(md[1]), 16'(mc[1])});
      chk("le_cycle", {vio_le, dist_le, cnt_le}, {mv[2], 16'(md[2]), 16'(mc[2])});
      chk("c4_cycle", {vio_c4, 12'd0, dist_c4, cnt_c4}, {mv[3], 16'(md[3]), 16'(mc[3])});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic v1, input logic v2);
    s1 = v1; s2 = v2; rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    do_reset(1'b0, 1'b0);
    chk("reset_state", {vio_ee, dist_ee, cnt_ee, vio_c4, dist_c4, cnt_c4}, 0);

    // EE: distance 7 under lim 10, then distance 10 at the limit
    lim_ee = 16'd10;
    s1 = 1; step(1);
    step(6);
    s2 = 1; step(1);
    chk("ee_vio", vio_ee, 1);
    chk("ee_dist", dist_ee, 7);
    chk("ee_cnt", cnt_ee, 1);
    step(1);
    chk("ee_pulse_one_cycle", vio_ee, 0);
    s1 = 0; s2 = 0; step(2);
    s1 = 1; step(1);
    step(9);
    s2 = 1; step(1);
    chk("ee_at_limit_no_vio", vio_ee, 0);
    chk("ee_at_limit_cnt", cnt_ee, 1);

    // EL: falling s2 two cycles after s1 rise
    lim_el = 16'd4; lim_ee = 16'd4;
    do_reset(1'b0, 1'b1);
    s1 = 1; step(1);
    step(1);
    s2 = 0; step(1);
    chk("el_vio", vio_el, 1);
    chk("el_dist", dist_el, 2);
    chk("ee_fall_ignored", vio_ee, 0);

    // LE: falling s1, rising s2 four cycles later
    lim_le = 16'd8;
    do_reset(1'b1, 1'b0);
    s1 = 0; step(1);
    step(3);
    s2 = 1; step(1);
    chk("le_vio", vio_le, 1);
    chk("le_dist", dist_le, 4);
    do_reset(1'b0, 1'b0);
    s2 = 1; step(1);
    chk("le_no_s1_no_vio", vio_le, 0);

    // Coincident s1/s2 events
    lim_ee = 16'd5;
    do_reset(1'b0, 1'b0);
    s1 = 1; step(1);
    s1 = 0; step(1);
    step(1);
    s1 = 1; s2 = 1; step(1);
    chk("sim_vio", vio_ee, 1);
    chk("sim_dist", dist_ee, 3);
    s2 = 0; step(1);
    step(5);
    s2 = 1; step(1);
    chk("sim_restart_no_vio", vio_ee, 0);
    chk("sim_cnt", cnt_ee, 1);

    // Reset discards a pending s1 event
    lim_ee = 16'd10;
    do_reset(1'b0, 1'b0);
    s1 = 1; step(1);
    rst = 1; s1 = 0; s2 = 1; step(1);
    chk("rst_holds_vio_low", vio_ee, 0);
    s1 = 1; s2 = 0; step(1);
    rst = 0; step(1);
    step(1);
    s2 = 1; step(1);
    chk("rst_no_vio", vio_ee, 0);
    chk("rst_cnt_zero", cnt_ee, 0);

    // CW=4 saturation and lim=0
    lim_c4 = 4'd15; lim_ee = 16'd0;
    do_reset(1'b0, 1'b0);
    s1 = 1; step(1);
    step(19);
    s2 = 1; step(1);
    chk("c4_sat_no_vio", vio_c4, 0);
    do_reset(1'b0, 1'b0);
    s1 = 1; step(1);
    s2 = 1; step(1);
    chk("lim0_no_vio", vio_ee, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        lim_ee = 16'($urandom_range(0, 20));
        lim_el = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 20));
        lim_le = 16'($urandom_range(0, 20));
        lim_c4 = 4'($urandom_range(0, 15));
      end
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) s1 = ~s1;
      if ($urandom_range(0, 2) == 0) s2 = ~s2;
      step(1);
    end

    // Violation counter saturation: EL violates every cycle here
    lim_el = 16'd10;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) begin
      s1 = ~s1; s2 = ~s2;
      step(1);
    end
    chk("vio_cnt_saturated", cnt_el, 16'hFFFF);
    chk("vio_still_pulsing", vio_el, 1);

    step(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
